// File: rtl/din_conditioner.sv
// Switch conditioner: synchronizes a raw button level, debounces it with a
// four-state FSM and emits one-cycle press/release strobes plus the clean level.
module din_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic din_pulse,
    output logic rel_pulse,
    output logic din_level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_RISE_CHK = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_FALL_CHK = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   din_pulse_q, din_pulse_d;
    logic                   rel_pulse_q, rel_pulse_d;
    logic                   din_level_q, din_level_d;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        din_pulse_d = 1'b0;
        rel_pulse_d = 1'b0;
        case (state_q)
            S_LOW: begin
                if (btn_sync) begin
                    state_d = S_RISE_CHK;
                    cnt_d   = '0;
                end
            end
            S_RISE_CHK: begin
                if (!btn_sync) begin
                    state_d = S_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_HIGH;
                    din_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!btn_sync) begin
                    state_d = S_FALL_CHK;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (btn_sync) begin
                    state_d = S_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_LOW;
                    rel_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
        // Level follows the state being entered so it rises with the press strobe.
        din_level_d = (state_d == S_HIGH) || (state_d == S_FALL_CHK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            state_q     <= S_LOW;
            cnt_q       <= '0;
            din_pulse_q <= 1'b0;
            rel_pulse_q <= 1'b0;
            din_level_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            din_pulse_q <= din_pulse_d;
            rel_pulse_q <= rel_pulse_d;
            din_level_q <= din_level_d;
        end
    end

    assign din_pulse = din_pulse_q;
    assign rel_pulse = rel_pulse_q;
    assign din_level = din_level_q;

endmodule

// File: tb/tb_din_conditioner.sv
// Directed bench for din_conditioner: a cycle table for the default build plus
// hand sequences for the press counter chain and a DEBOUNCE_CYCLES=1 build.
module tb_din_conditioner;

    typedef struct {
        logic rst;
        logic btn;
        logic exp_p;
        logic exp_r;
        logic exp_l;
    } vec_t;

    logic clk = 1'b0;
    logic reset0 = 1'b1, btn0 = 1'b0;
    logic reset1 = 1'b1, btn1 = 1'b0;
    logic p0, r0, l0, p1, r1, l1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    din_conditioner #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) u_def (
        .clk(clk), .reset(reset0), .btn_in(btn0),
        .din_pulse(p0), .rel_pulse(r0), .din_level(l0)
    );

    din_conditioner #(.DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)) u_one (
        .clk(clk), .reset(reset1), .btn_in(btn1),
        .din_pulse(p1), .rel_pulse(r1), .din_level(l1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got {pulse,rel,level}=%b expected %b", name, act, exp);
        end
    endtask

    function automatic void push(input logic rst, input logic btn,
                                 input logic p, input logic r, input logic l);
        vec_t v;
        v.rst = rst; v.btn = btn; v.exp_p = p; v.exp_r = r; v.exp_l = l;
        vecs.push_back(v);
    endfunction

    initial begin
        int z;
        int npulse;

        // Reset state.
        push(1, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0);
        // Clean press held 20 cycles: strobe after edge 6 only, level from 6 on.
        for (int i = 0; i < 20; i++) push(0, 1, i == 6, 0, i >= 6);
        // Release: strobe after edge 6, level held through the falling check.
        for (int i = 0; i < 10; i++) push(0, 0, 0, i == 6, i < 6);
        // 3-cycle glitch, 5 low, then a held press accepted 6 edges after the rise.
        for (int i = 0; i < 3; i++) push(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) push(0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) push(0, 1, i == 6, 0, i >= 6);
        for (int i = 0; i < 10; i++) push(0, 0, 0, i == 6, i < 6);
        // Reset at edge 4 of a press, press held afterwards.
        for (int i = 0; i < 4; i++) push(0, 1, 0, 0, 0);
        push(1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) push(0, 1, i == 6, 0, i >= 6);
        for (int i = 0; i < 10; i++) push(0, 0, 0, i == 6, i < 6);

        foreach (vecs[i]) begin
            reset0 = vecs[i].rst;
            btn0   = vecs[i].btn;
            tick();
            chk($sformatf("vec%0d", i), {p0, r0, l0},
                {vecs[i].exp_p, vecs[i].exp_r, vecs[i].exp_l});
        end

        // Downstream 2-bit counter fed by din_pulse across 4 clean presses.
        z = 0;
        for (int k = 0; k < 4; k++) begin
            npulse = 0;
            btn0 = 1'b1;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (p0) begin
                    npulse++;
                    z = (z + 1) % 4;
                end
            end
            btn0 = 1'b0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (p0) begin
                    npulse++;
                    z = (z + 1) % 4;
                end
            end
            checks++;
            if (z != (k + 1) % 4 || npulse != 1) begin
                errors++;
                $display("FAIL chain_press%0d z=%0d pulses=%0d expected z=%0d pulses=1",
                         k, z, npulse, (k + 1) % 4);
            end
        end

        // DEBOUNCE_CYCLES=1: press latency of 3 edges.
        reset1 = 1'b1;
        tick();
        chk("one_reset", {p1, r1, l1}, 3'b000);
        reset1 = 1'b0;
        btn1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("one_press%0d", i), {p1, r1, l1},
                {i == 3, 1'b0, i >= 3});
        end
        btn1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("one_rel%0d", i), {p1, r1, l1},
                {1'b0, i == 3, i < 3});
        end
        // Shortest glitch passed: one sample enters the check, the next accepts it.
        btn1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) btn1 = 1'b0;
            tick();
            chk($sformatf("one_glitch%0d", i), {p1, r1, l1},
                {i == 3, i == 5, i == 3 || i == 4});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
